// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU front end: FSM states,
// default widths and the ALU operation select encodings.
package alu_arb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // ADD is encoded as 8, which folds onto 0 once truncated to the select width
    localparam logic [OP_W_DEF-1:0] ALU_AND  = OP_W_DEF'(1);
    localparam logic [OP_W_DEF-1:0] ALU_OR   = OP_W_DEF'(2);
    localparam logic [OP_W_DEF-1:0] ALU_XOR  = OP_W_DEF'(3);
    localparam logic [OP_W_DEF-1:0] ALU_NAND = OP_W_DEF'(4);
    localparam logic [OP_W_DEF-1:0] ALU_NOR  = OP_W_DEF'(5);
    localparam logic [OP_W_DEF-1:0] ALU_XNOR = OP_W_DEF'(7);
    localparam logic [OP_W_DEF-1:0] ALU_ADD  = OP_W_DEF'(8);

endpackage

// File: rtl/alu_arb_rr2.sv
// Two-input grant logic. With ALU_ARB_RR_EN defined a tie goes to the
// requester that did not win last time; otherwise requester 0 wins ties.
// A lone request always wins.
module alu_arb_rr2 (
    input  logic [1:0] req,
`ifdef ALU_ARB_RR_EN
    input  logic       last_grant,
`endif
    output logic [1:0] gnt
);

    // One-hot grant from the current request vector
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            gnt = last_grant ? 2'b01 : 2'b10;
`else
            gnt = 2'b01;
`endif
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one externally registered ALU between two requesters. One
// transaction at a time: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
// Build option: define ALU_ARB_RR_EN for round-robin tie breaking;
// default is fixed priority to requester 0.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [2*OP_W-1:0]   req_op,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [2:0]          rsp_flags,
    output logic [DATA_W-1:0]   alu_inA,
    output logic [DATA_W-1:0]   alu_inB,
    output logic [OP_W-1:0]     alu_sel,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zero,
    input  logic                alu_carry,
    input  logic                alu_overF,
    output logic                busy,
    output logic [15:0]         op_count
);

    state_t              state_q, state_d;
    logic [1:0]          gnt;
    logic                grant_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [2:0]          rsp_flags_q;
    logic [15:0]         op_cnt_q;
    logic                accept;
    logic                rsp_hs;
`ifdef ALU_ARB_RR_EN
    logic                last_grant_q;
`endif

    alu_arb_rr2 u_arb (
        .req        (req_valid),
`ifdef ALU_ARB_RR_EN
        .last_grant (last_grant_q),
`endif
        .gnt        (gnt)
    );

    assign accept    = (state_q == ST_IDLE) && (|gnt);
    assign rsp_hs    = (state_q == ST_RESP) && rsp_ready[grant_q];
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign op_count  = op_cnt_q;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and all state-decoded outputs; the ALU sees zeros except in ISSUE
    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        alu_inA   = '0;
        alu_inB   = '0;
        alu_sel   = '0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (reset) req_ready = gnt;
                if (|gnt)  state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                alu_inA = a_q;
                alu_inB = b_q;
                alu_sel = op_q;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Winner index, round-robin history and completed-transaction counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q      <= 1'b0;
            op_cnt_q     <= 16'd0;
`ifdef ALU_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            if (accept) begin
                grant_q      <= gnt[1];
`ifdef ALU_ARB_RR_EN
                last_grant_q <= gnt[1];
`endif
            end
            if (rsp_hs) op_cnt_q <= op_cnt_q + 16'd1;
        end
    end

    // Latch the winner's operands and select at the request handshake
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= req_a[DATA_W*gnt[1] +: DATA_W];
            b_q  <= req_b[DATA_W*gnt[1] +: DATA_W];
            op_q <= req_op[OP_W*gnt[1] +: OP_W];
        end
    end

    // Capture the ALU output one cycle after ISSUE; held through RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_data_q  <= '0;
            rsp_flags_q <= 3'b000;
        end else if (state_q == ST_CAPTURE) begin
            rsp_data_q  <= alu_result;
            rsp_flags_q <= {alu_overF, alu_carry, alu_zero};
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-plus-random bench for alu_arbiter with a registered ALU model
// and a transaction-level reference for grants, results and the counter.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid, req_ready;
    logic [15:0] req_a, req_b;
    logic [5:0]  req_op;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [7:0]  rsp_data;
    logic [2:0]  rsp_flags;
    logic [7:0]  alu_inA, alu_inB, alu_result;
    logic [2:0]  alu_sel;
    logic        alu_zero, alu_carry, alu_overF;
    logic        busy;
    logic [15:0] op_count;

    int          n_cmp;
    int          n_fail;
    logic [15:0] exp_cnt;
`ifdef ALU_ARB_RR_EN
    int          last_win;
`endif

    alu_arbiter #(.DATA_W(8), .OP_W(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_overF(alu_overF),
        .busy(busy), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {overF, carry, zero, result}
    function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] sel);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v;
        s = {1'b0, a} + {1'b0, b};
        c = 1'b0;
        v = 1'b0;
        case (sel)
            ALU_ADD: begin
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NAND: r = ~(a & b);
            ALU_NOR:  r = ~(a | b);
            ALU_XNOR: r = ~(a ^ b);
            default:  r = a - b;
        endcase
        return {v, c, (r == 8'h00), r};
    endfunction

    // External ALU with one cycle of latency
    always @(posedge clk)
        {alu_overF, alu_carry, alu_zero, alu_result} <= alu_f(alu_inA, alu_inB, alu_sel);

    function automatic int winner(input logic [1:0] v);
        if (v == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            return (last_win == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        return v[1] ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_req_ready"}, 32'(req_ready), 0);
        check({pfx, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({pfx, "_rsp_data"},  32'(rsp_data),  0);
        check({pfx, "_rsp_flags"}, 32'(rsp_flags), 0);
        check({pfx, "_alu_inA"},   32'(alu_inA),   0);
        check({pfx, "_alu_inB"},   32'(alu_inB),   0);
        check({pfx, "_alu_sel"},   32'(alu_sel),   0);
        check({pfx, "_busy"},      32'(busy),      0);
        check({pfx, "_op_count"},  32'(op_count),  0);
    endtask

    task automatic model_reset();
        exp_cnt = 16'd0;
`ifdef ALU_ARB_RR_EN
        last_win = 1;
`endif
    endtask

    // Full transaction: request, ISSUE, CAPTURE, RESP with optional stall
    task automatic txn(input logic [1:0] vld,
                       input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] op0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] op1,
                       input int stall, input logic poke_other, output int g_obs);
        int          w;
        logic [1:0]  oh;
        logic [7:0]  ea, eb;
        logic [2:0]  eo;
        logic [10:0] m;
        w  = winner(vld);
        oh = (w == 1) ? 2'b10 : 2'b01;
        ea = (w == 1) ? a1 : a0;
        eb = (w == 1) ? b1 : b0;
        eo = (w == 1) ? op1 : op0;
        m  = alu_f(ea, eb, eo);
        @(negedge clk);
        req_valid = vld;
        req_a = {a1, a0};
        req_b = {b1, b0};
        req_op = {op1, op0};
        rsp_ready = 2'b00;
        #1;
        g_obs = req_ready[1] ? 1 : 0;
        check("idle_req_ready", 32'(req_ready), 32'(oh));
        check("idle_busy", 32'(busy), 0);
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("issue_busy", 32'(busy), 1);
        check("issue_req_ready", 32'(req_ready), 0);
        check("issue_alu_inA", 32'(alu_inA), 32'(ea));
        check("issue_alu_inB", 32'(alu_inB), 32'(eb));
        check("issue_alu_sel", 32'(alu_sel), 32'(eo));
        check("issue_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        check("capture_alu_ops", 32'({alu_inA, alu_inB, alu_sel}), 0);
        check("capture_rsp_valid", 32'(rsp_valid), 0);
        check("capture_req_ready", 32'(req_ready), 0);
        @(negedge clk);
        check("resp_rsp_valid", 32'(rsp_valid), 32'(oh));
        check("resp_rsp_data", 32'(rsp_data), 32'(m[7:0]));
        check("resp_rsp_flags", 32'(rsp_flags), 32'(m[10:8]));
        for (int i = 0; i < stall; i++) begin
            rsp_ready = poke_other ? ~oh : 2'b00;
            @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 32'(oh));
            check("stall_rsp_data", 32'(rsp_data), 32'(m[7:0]));
            check("stall_rsp_flags", 32'(rsp_flags), 32'(m[10:8]));
            check("stall_req_ready", 32'(req_ready), 0);
            check("stall_busy", 32'(busy), 1);
        end
        req_valid = 2'b00;
        rsp_ready = oh | (poke_other ? ~oh : 2'b00);
        exp_cnt = exp_cnt + 16'd1;
`ifdef ALU_ARB_RR_EN
        last_win = w;
`endif
        @(negedge clk);
        rsp_ready = 2'b00;
        check("done_rsp_valid", 32'(rsp_valid), 0);
        check("done_busy", 32'(busy), 0);
        check("done_op_count", 32'(op_count), 32'(exp_cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 2'b11;
        reset = 1'b0;
        #1;
        check_quiet("reset");
        @(negedge clk);
        req_valid = 2'b00;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int g;
        int seq[4];
        logic [1:0] v;
        n_cmp = 0;
        n_fail = 0;
        model_reset();
        reset = 1'b0;
        req_valid = 2'b00;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = 2'b00;
        repeat (2) @(negedge clk);
        do_reset();

        // Single requester 0, AND of 0F and 3C
        txn(2'b01, 8'h0F, 8'h3C, 3'd1, 8'h00, 8'h00, 3'd0, 0, 1'b0, g);
        check("directed_and_data", 32'(rsp_data), 32'h0C);
        check("directed_grant", 32'(g), 0);
        check("directed_count", 32'(op_count), 1);

        // Randomized traffic with random stalls and stray rsp_ready on the other bit
        for (int k = 0; k < 10; k++) begin
            v = 2'($urandom_range(1, 3));
            txn(v, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), g);
        end

        // ADD overflow and zero corner cases
        txn(2'b10, 8'h00, 8'h00, 3'd0, 8'h80, 8'h80, ALU_ADD, 0, 1'b0, g);
        txn(2'b01, 8'h7F, 8'h01, ALU_ADD, 8'h00, 8'h00, 3'd0, 0, 1'b0, g);

        // Both requesting from reset over four transactions
        do_reset();
`ifdef ALU_ARB_RR_EN
        seq = '{0, 1, 0, 1};
`else
        seq = '{0, 0, 0, 0};
`endif
        for (int k = 0; k < 4; k++) begin
            txn(2'b11, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 0, 1'b0, g);
            check("tie_grant_seq", 32'(g), 32'(seq[k]));
        end

        // Five-cycle response stall, then stray rsp_ready[1] while serving requester 0
        txn(2'b01, 8'hA5, 8'h5A, ALU_XOR, 8'h00, 8'h00, 3'd0, 5, 1'b0, g);
        txn(2'b01, 8'hF0, 8'h0F, ALU_NOR, 8'h11, 8'h22, 3'd2, 4, 1'b1, g);

        // A request pulse that ends before any clock edge is ignored
        @(negedge clk);
        req_valid = 2'b01;
        #2;
        req_valid = 2'b00;
        @(negedge clk);
        check("dropped_req_busy", 32'(busy), 0);
        check("dropped_req_count", 32'(op_count), 32'(exp_cnt));

        // Reset asserted while the operation sits in CAPTURE
        @(negedge clk);
        req_valid = 2'b01;
        req_a = 16'h0033;
        req_b = 16'h0044;
        req_op = 6'o02;
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_quiet("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_reset_rsp_valid", 32'(rsp_valid), 0);
            check("post_reset_busy", 32'(busy), 0);
        end
        check("post_reset_count", 32'(op_count), 0);
        txn(2'b10, 8'h00, 8'h00, 3'd0, 8'h12, 8'h34, ALU_OR, 1, 1'b0, g);

        // Counter wrap from FFFF
        @(negedge clk);
        force dut.op_cnt_q = 16'hFFFF;
        #1;
        release dut.op_cnt_q;
        #1;
        check("forced_count", 32'(op_count), 32'hFFFF);
        exp_cnt = 16'hFFFF;
        txn(2'b01, 8'h01, 8'h02, ALU_ADD, 8'h00, 8'h00, 3'd0, 0, 1'b0, g);
        check("wrap_count", 32'(op_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
